// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//
// Walks a pixel/line raster of HT x VT positions. Each position lasts DIV
// pclk cycles. All outputs decode the current counter state in the same
// cycle, so they describe one raster position together.
//
// Ports
//   pclk        pixel clock (single clock domain)
//   reset       synchronous, active-high; returns the raster to (0,0)
//   en          run enable; low freezes the raster and the divider
//   hsync       horizontal sync, active level HSYNC_POL
//   vsync       vertical sync, active level VSYNC_POL (line granular)
//   valid       current position is inside the active area
//   h_cnt       active-area x, 0 outside the active area
//   v_cnt       active-area y, 0 outside the active area
//   pix_tick    last pclk cycle of the current pixel position
//   line_start  one-cycle strobe at pixel 0 of any line
//   frame_start one-cycle strobe at pixel 0 of line 0
module vga_timing_gen #(
    parameter int HD        = 640,
    parameter int HF        = 16,
    parameter int HS        = 96,
    parameter int HB        = 48,
    parameter int VD        = 480,
    parameter int VF        = 10,
    parameter int VS        = 2,
    parameter int VB        = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int CW        = 10,
    parameter int DIV       = 1
) (
    input  logic          pclk,
    input  logic          reset,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          valid,
    output logic [CW-1:0] h_cnt,
    output logic [CW-1:0] v_cnt,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start
);

    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    if (HT > (1 << CW)) begin : g_bad_ht
        $error("vga_timing_gen: HT does not fit in CW bits");
    end
    if (VT > (1 << CW)) begin : g_bad_vt
        $error("vga_timing_gen: VT does not fit in CW bits");
    end
    if (DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: DIV must be at least 1");
    end

    // Decode thresholds are one bit wider than the counters so that a
    // threshold equal to 2^CW still compares correctly.
    localparam logic [CW:0] HD_L  = (CW+1)'(HD);
    localparam logic [CW:0] HSS_L = (CW+1)'(HD + HF);
    localparam logic [CW:0] HSE_L = (CW+1)'(HD + HF + HS);
    localparam logic [CW:0] VD_L  = (CW+1)'(VD);
    localparam logic [CW:0] VSS_L = (CW+1)'(VD + VF);
    localparam logic [CW:0] VSE_L = (CW+1)'(VD + VF + VS);

    localparam logic [CW-1:0] HT_M1 = CW'(HT - 1);
    localparam logic [CW-1:0] VT_M1 = CW'(VT - 1);

    localparam logic HP = (HSYNC_POL != 0);
    localparam logic VP = (VSYNC_POL != 0);

    logic          div_last;
    logic [CW-1:0] pixel_cnt;
    logic [CW-1:0] line_cnt;
    logic [CW:0]   px;
    logic [CW:0]   ln;

    // Pixel-clock divider. With DIV == 1 every enabled cycle is the last
    // cycle of its pixel, so no register exists at all.
    if (DIV == 1) begin : g_nodiv
        assign div_last = 1'b1;
    end else begin : g_div
        localparam int DW = $clog2(DIV);
        localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);

        logic [DW-1:0] div_cnt;

        always_ff @(posedge pclk) begin
            if (reset) begin
                div_cnt <= '0;
            end else if (en) begin
                if (div_last) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end

        assign div_last = (div_cnt == DIV_M1);
    end

    assign pix_tick = en && div_last;

    // Raster position; advances only on pix_tick, line advances on pixel wrap.
    always_ff @(posedge pclk) begin
        if (reset) begin
            pixel_cnt <= '0;
            line_cnt  <= '0;
        end else if (pix_tick) begin
            if (pixel_cnt == HT_M1) begin
                pixel_cnt <= '0;
                if (line_cnt == VT_M1) begin
                    line_cnt <= '0;
                end else begin
                    line_cnt <= line_cnt + 1'b1;
                end
            end else begin
                pixel_cnt <= pixel_cnt + 1'b1;
            end
        end
    end

    // Outputs are a pure decode of the current state, so they share
    // one alignment with no pipeline skew.
    assign px = {1'b0, pixel_cnt};
    assign ln = {1'b0, line_cnt};

    assign valid       = (px < HD_L) && (ln < VD_L);
    assign h_cnt       = valid ? pixel_cnt : '0;
    assign v_cnt       = valid ? line_cnt  : '0;
    assign hsync       = ((px >= HSS_L) && (px < HSE_L)) ? HP : ~HP;
    assign vsync       = ((ln >= VSS_L) && (ln < VSE_L)) ? VP : ~VP;
    assign line_start  = pix_tick && (pixel_cnt == '0);
    assign frame_start = line_start && (line_cnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: self-checking bench for vga_timing_gen.
//
// Three instances share one clock: a tiny raster (DIV=1, active-high hsync),
// a medium raster (DIV=2) and the full 640x480 raster (DIV=4). Every cycle
// an expected output word per instance is computed from an absolute raster
// index and queued, then popped and compared against the DUT on the falling
// edge. Feature tasks add direct checks against hand-derived constants.
module tb_vga_timing_gen;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic rst [3];
    logic en  [3];
    logic hs  [3];
    logic vs  [3];
    logic vl  [3];
    logic tk  [3];
    logic ls  [3];
    logic fs  [3];
    logic [3:0] h0, v0;
    logic [5:0] h1, v1;
    logic [9:0] h2, v2;

    vga_timing_gen #(
        .HD(4), .HF(1), .HS(2), .HB(1), .VD(3), .VF(1), .VS(1), .VB(1),
        .HSYNC_POL(1), .VSYNC_POL(0), .CW(4), .DIV(1)
    ) u_small (
        .pclk(pclk), .reset(rst[0]), .en(en[0]), .hsync(hs[0]), .vsync(vs[0]),
        .valid(vl[0]), .h_cnt(h0), .v_cnt(v0), .pix_tick(tk[0]),
        .line_start(ls[0]), .frame_start(fs[0])
    );

    vga_timing_gen #(
        .HD(20), .HF(3), .HS(4), .HB(5), .VD(12), .VF(2), .VS(2), .VB(3),
        .CW(6), .DIV(2)
    ) u_mid (
        .pclk(pclk), .reset(rst[1]), .en(en[1]), .hsync(hs[1]), .vsync(vs[1]),
        .valid(vl[1]), .h_cnt(h1), .v_cnt(v1), .pix_tick(tk[1]),
        .line_start(ls[1]), .frame_start(fs[1])
    );

    vga_timing_gen #(
        .DIV(4)
    ) u_full (
        .pclk(pclk), .reset(rst[2]), .en(en[2]), .hsync(hs[2]), .vsync(vs[2]),
        .valid(vl[2]), .h_cnt(h2), .v_cnt(v2), .pix_tick(tk[2]),
        .line_start(ls[2]), .frame_start(fs[2])
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vl;
        logic [9:0] h;
        logic [9:0] v;
        logic       tk;
        logic       ls;
        logic       fs;
    } obs_t;

    int g_hd  [3] = '{4, 20, 640};
    int g_hf  [3] = '{1, 3, 16};
    int g_hs  [3] = '{2, 4, 96};
    int g_hb  [3] = '{1, 5, 48};
    int g_vd  [3] = '{3, 12, 480};
    int g_vf  [3] = '{1, 2, 10};
    int g_vs  [3] = '{1, 2, 2};
    int g_vb  [3] = '{1, 3, 33};
    int g_hp  [3] = '{1, 0, 0};
    int g_vp  [3] = '{0, 0, 0};
    int g_div [3] = '{1, 2, 4};

    int   m_t [3];   // absolute raster position index within the frame
    int   m_d [3];   // cycle index within the current position
    obs_t last [3];
    obs_t sb [$];
    int   total = 0;
    int   bad = 0;
    int   cyc_no = 0;

    function automatic obs_t model_out(input int i);
        obs_t o;
        int ht, x, y;
        ht = g_hd[i] + g_hf[i] + g_hs[i] + g_hb[i];
        x = m_t[i] % ht;
        y = m_t[i] / ht;
        o.tk = en[i] && (m_d[i] == g_div[i] - 1);
        o.vl = (x < g_hd[i]) && (y < g_vd[i]);
        o.h  = o.vl ? 10'(x) : 10'd0;
        o.v  = o.vl ? 10'(y) : 10'd0;
        o.hs = (x >= g_hd[i] + g_hf[i] && x < g_hd[i] + g_hf[i] + g_hs[i])
               ? (g_hp[i] != 0) : (g_hp[i] == 0);
        o.vs = (y >= g_vd[i] + g_vf[i] && y < g_vd[i] + g_vf[i] + g_vs[i])
               ? (g_vp[i] != 0) : (g_vp[i] == 0);
        o.ls = o.tk && (x == 0);
        o.fs = o.ls && (y == 0);
        return o;
    endfunction

    function automatic void model_step(input int i);
        int ht, vt;
        ht = g_hd[i] + g_hf[i] + g_hs[i] + g_hb[i];
        vt = g_vd[i] + g_vf[i] + g_vs[i] + g_vb[i];
        if (rst[i]) begin
            m_t[i] = 0;
            m_d[i] = 0;
        end else if (en[i]) begin
            if (m_d[i] == g_div[i] - 1) begin
                m_d[i] = 0;
                m_t[i] = (m_t[i] + 1) % (ht * vt);
            end else begin
                m_d[i] = m_d[i] + 1;
            end
        end
    endfunction

    function automatic obs_t observe(input int i);
        obs_t o;
        o.hs = hs[i]; o.vs = vs[i]; o.vl = vl[i];
        o.tk = tk[i]; o.ls = ls[i]; o.fs = fs[i];
        case (i)
            0:       begin o.h = {6'd0, h0}; o.v = {6'd0, v0}; end
            1:       begin o.h = {4'd0, h1}; o.v = {4'd0, v1}; end
            default: begin o.h = h2;         o.v = v2;         end
        endcase
        return o;
    endfunction

    // One clock cycle: queue expectations for the current state and inputs,
    // compare on the falling edge, then advance the models with the edge.
    task automatic cycle();
        obs_t e, o;
        for (int i = 0; i < 3; i++) sb.push_back(model_out(i));
        @(negedge pclk);
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            o = observe(i);
            last[i] = o;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL sb_dut%0d cyc=%0d got=%h exp=%h", i, cyc_no, o, e);
            end
        end
        @(posedge pclk);
        for (int i = 0; i < 3; i++) model_step(i);
        cyc_no++;
        #1;
    endtask

    // Cycle without comparison, used while outputs are still unknown.
    task automatic skip_cycle();
        @(posedge pclk);
        for (int i = 0; i < 3; i++) model_step(i);
        cyc_no++;
        #1;
    endtask

    task automatic reset_all();
        for (int i = 0; i < 3; i++) begin rst[i] = 1'b1; en[i] = 1'b1; end
        skip_cycle();
        skip_cycle();
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    endtask

    task automatic test_reset();
        reset_all();
        cycle();
        total++;
        if (!(last[0].fs === 1'b1 && last[0].ls === 1'b1 && last[0].tk === 1'b1)) begin
            bad++;
            $display("FAIL reset_strobes_div1 got=%b%b%b want=111", last[0].tk, last[0].ls, last[0].fs);
        end
        total++;
        if (!(last[2].fs === 1'b0 && last[2].tk === 1'b0)) begin
            bad++;
            $display("FAIL reset_strobes_div4 got=%b%b want=00", last[2].tk, last[2].fs);
        end
        total++;
        if (!(last[0].hs === 1'b0 && last[0].vs === 1'b1 && last[2].hs === 1'b1 && last[2].vs === 1'b1)) begin
            bad++;
            $display("FAIL reset_syncs got=%b%b%b%b want=0111", last[0].hs, last[0].vs, last[2].hs, last[2].vs);
        end
        total++;
        if (!(last[2].vl === 1'b1 && last[2].h === 10'd0 && last[2].v === 10'd0)) begin
            bad++;
            $display("FAIL reset_pos got=%b/%0d/%0d want=1/0/0", last[2].vl, last[2].h, last[2].v);
        end
    endtask

    task automatic test_small_raster();
        int hs_first = -1, hs_n = 0, vs_first = -1, vs_n = 0, fs_n = 0;
        int fs_k [3];
        reset_all();
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (k < 8 && last[0].hs === 1'b1) begin
                if (hs_first < 0) hs_first = k;
                hs_n++;
            end
            if (k < 48 && last[0].vs === 1'b0) begin
                if (vs_first < 0) vs_first = k;
                vs_n++;
            end
            if (last[0].fs === 1'b1) begin
                if (fs_n < 3) fs_k[fs_n] = k;
                fs_n++;
            end
        end
        total++;
        if (hs_first != 5 || hs_n != 2) begin
            bad++;
            $display("FAIL small_hsync got=first%0d/n%0d want=first5/n2", hs_first, hs_n);
        end
        total++;
        if (vs_first != 32 || vs_n != 8) begin
            bad++;
            $display("FAIL small_vsync got=first%0d/n%0d want=first32/n8", vs_first, vs_n);
        end
        total++;
        if (fs_n != 3 || fs_k[0] != 0 || fs_k[1] != 48 || fs_k[2] != 96) begin
            bad++;
            $display("FAIL small_frame_period got=n%0d at %0d,%0d,%0d want=n3 at 0,48,96",
                     fs_n, fs_k[0], fs_k[1], fs_k[2]);
        end
    endtask

    task automatic test_div4_line();
        int tk_n = 0, ls_n = 0, hs_first = -1, hs_n = 0, h_at30 = -1;
        int ls_k [2];
        reset_all();
        for (int k = 0; k < 6400; k++) begin
            cycle();
            if (k < 400 && last[2].tk === 1'b1) tk_n++;
            if (last[2].ls === 1'b1) begin
                if (ls_n < 2) ls_k[ls_n] = k;
                ls_n++;
            end
            if (k < 3200 && last[2].hs === 1'b0) begin
                if (hs_first < 0) hs_first = k;
                hs_n++;
            end
            if (k == 30) h_at30 = int'(last[2].h);
        end
        total++;
        if (tk_n != 100) begin
            bad++;
            $display("FAIL div4_tick_rate got=%0d want=100", tk_n);
        end
        total++;
        if (ls_n != 2 || ls_k[0] != 3 || ls_k[1] != 3203) begin
            bad++;
            $display("FAIL div4_line_start got=n%0d at %0d,%0d want=n2 at 3,3203", ls_n, ls_k[0], ls_k[1]);
        end
        total++;
        if (hs_first != 2624 || hs_n != 384) begin
            bad++;
            $display("FAIL div4_hsync got=first%0d/n%0d want=first2624/n384", hs_first, hs_n);
        end
        total++;
        if (h_at30 != 7) begin
            bad++;
            $display("FAIL div4_hcnt_step got=%0d want=7", h_at30);
        end
    endtask

    task automatic test_pause();
        int held = 0;
        reset_all();
        // 341 cycles puts the DIV=2 raster at pixel 10 of line 5, second half
        for (int k = 0; k < 341; k++) cycle();
        en[1] = 1'b0;
        for (int k = 0; k < 37; k++) begin
            cycle();
            if (last[1].h === 6'd10 && last[1].v === 6'd5 && last[1].tk === 1'b0 &&
                last[1].ls === 1'b0) held++;
        end
        total++;
        if (held != 37) begin
            bad++;
            $display("FAIL pause_hold got=%0d want=37", held);
        end
        en[1] = 1'b1;
        cycle();
        total++;
        if (!(last[1].h === 10'd10 && last[1].tk === 1'b1)) begin
            bad++;
            $display("FAIL pause_resume got=h%0d/t%b want=h10/t1", last[1].h, last[1].tk);
        end
        cycle();
        total++;
        if (!(last[1].h === 10'd11 && last[1].tk === 1'b0)) begin
            bad++;
            $display("FAIL pause_next got=h%0d/t%b want=h11/t0", last[1].h, last[1].tk);
        end
    endtask

    task automatic test_reset_mid();
        int fs_n = 0;
        int fs_k [2];
        for (int k = 0; k < 57; k++) cycle();
        rst[1] = 1'b1;
        en[1] = 1'b0;
        cycle();
        rst[1] = 1'b0;
        cycle();
        total++;
        if (!(last[1].h === 10'd0 && last[1].v === 10'd0 && last[1].vl === 1'b1 &&
              last[1].hs === 1'b1 && last[1].vs === 1'b1 && last[1].tk === 1'b0)) begin
            bad++;
            $display("FAIL reset_mid_pos got=%h want=h0 v0 valid1 syncs inactive", last[1]);
        end
        en[1] = 1'b1;
        for (int k = 0; k < 2500; k++) begin
            cycle();
            if (last[1].fs === 1'b1) begin
                if (fs_n < 2) fs_k[fs_n] = k;
                fs_n++;
            end
        end
        total++;
        if (fs_n < 2) begin
            bad++;
            $display("FAIL reset_mid_frame got=%0d strobes want>=2", fs_n);
        end else begin
            total++;
            if (fs_k[0] != 1 || fs_k[1] - fs_k[0] != 1216) begin
                bad++;
                $display("FAIL reset_mid_period got=%0d,%0d want=1,1217", fs_k[0], fs_k[1]);
            end
        end
    endtask

    task automatic test_random_en();
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 3; i++) en[i] = ($urandom_range(0, 3) != 0);
            cycle();
        end
        for (int i = 0; i < 3; i++) en[i] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; m_t[i] = 0; m_d[i] = 0;
        end
        test_reset();
        test_small_raster();
        test_div4_line();
        test_pause();
        test_reset_mid();
        test_random_en();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It is the drop-in successor to the fixed 640x480 controller. Horizontal and vertical geometry, sync polarity, counter width and pixel-clock division are all configurable. Outputs are aligned: hsync, vsync, valid, coordinates and strobes all describe the same raster position in the same cycle. Run/pause control and single-cycle line and frame strobes feed the pixel pipeline and the frame-synchronous game logic.

## Interface
- HD, 640, active pixels per line
- HF, 16, horizontal front porch (pixels)
- HS, 96, hsync width (pixels)
- HB, 48, horizontal back porch (pixels)
- VD, 480, active lines per frame
- VF, 10, vertical front porch (lines)
- VS, 2, vsync width (lines)
- VB, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- CW, 10, counter/coordinate width
- DIV, 1, pclk cycles per pixel (>=1)
- pclk  input  1  clock; one clock domain only
- reset  input  1  synchronous, active-high
- en  input  1  run enable; low freezes the raster
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- valid  output  1  current position is inside the active area
- h_cnt  output  CW  active-area x; 0 when outside the active area
- v_cnt  output  CW  active-area y; 0 when outside the active area
- pix_tick  output  1  last pclk cycle of the current pixel position
- line_start  output  1  one-cycle strobe at pixel 0 of any line
- frame_start  output  1  one-cycle strobe at pixel 0 of line 0

## Operation
- Derived constants: HT = HD+HF+HS+HB and VT = VD+VF+VS+VB. Elaboration fails if HT > 2^CW, VT > 2^CW or DIV < 1.
- State registers:
  - div_cnt: 0..DIV-1.
  - pixel_cnt: 0..HT-1.
  - line_cnt: 0..VT-1.
- pix_tick = en && (div_cnt == DIV-1). It is combinational from state.
- Each pclk edge:
  - If reset: all three counters go to 0.
  - Else if !en: all three counters hold.
  - Else if !pix_tick: div_cnt increments.
  - Else (pix_tick): div_cnt goes to 0 and pixel_cnt advances.
- pixel_cnt advance: increments, or wraps HT-1 -> 0.
- line_cnt advances only when pixel_cnt wraps. It increments, or wraps VT-1 -> 0.
- All outputs decode the current counter values, with no pipeline skew between them:
  - valid = pixel_cnt < HD && line_cnt < VD.
  - h_cnt = pixel_cnt if pixel_cnt < HD, else 0.
  - v_cnt = line_cnt if line_cnt < VD, else 0.
  - hsync = HSYNC_POL when HD+HF <= pixel_cnt < HD+HF+HS, else ~HSYNC_POL.
  - vsync = VSYNC_POL when VD+VF <= line_cnt < VD+VF+VS, else ~VSYNC_POL. vsync is line-granular and changes together with the pixel 0 position.
  - line_start = pix_tick && pixel_cnt == 0.
  - frame_start = line_start && line_cnt == 0.
- Sinks sample pixel data on pix_tick. With DIV=1, pix_tick equals en.
- Implementations register hsync/vsync with a one-pixel lookahead, or decode them combinationally; either way the cycle alignment above is mandatory.

## Timing
- State after reset, i.e. the first cycle with reset low:
  - Counters: pixel_cnt = 0, line_cnt = 0, div_cnt = 0.
  - valid = 1, h_cnt = 0, v_cnt = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - pix_tick = line_start = frame_start = (en && DIV == 1).
- Position timing with en held high:
  - Each raster position is presented for exactly DIV cycles.
  - Line period is HT*DIV cycles.
  - Frame period is HT*VT*DIV cycles.
- en low:
  - Counters and outputs are frozen at the current position.
  - pix_tick, line_start and frame_start are 0.
  - When en returns high, div_cnt resumes from its held value. No pixel is skipped or repeated.
- reset mid-frame: the next cycle is position (0,0) with div_cnt = 0, regardless of en. reset has priority over en.
- Simultaneous wrap (pixel HT-1, line VT-1, pix_tick): the next position is (0,0). frame_start is asserted in the first cycle at (0,0) that has pix_tick.
- Boundaries:
  - hsync deasserts at pixel HD+HF+HS, not at HD+HF+HS-1.
  - valid drops at pixel HD and at line VD.
  - DIV = 1 requires no divider register and must synthesise correctly.

## Test plan
- Defaults, en = 1 after reset:
  - hsync is low exactly at pixels 656..751 of line 0.
  - line_start repeats every 800 cycles.
  - frame_start repeats every 420000 cycles.
  - valid is high for 307200 cycles per frame.
- Defaults:
  - vsync is low exactly while line_cnt is 490..491, i.e. for 1600 consecutive cycles starting at pixel 0 of line 490.
  - h_cnt = v_cnt = 0 in all blanking cycles.
- DIV = 4:
  - h_cnt steps once every 4 cycles.
  - pix_tick is high 1 cycle in 4.
  - The frame period is 1680000 cycles.
  - line_start is exactly 1 cycle wide.
- en pulled low for 37 cycles at pixel 300 of line 10 with DIV = 2 (en dropped with div_cnt = 1):
  - Outputs hold at (300,10) and pix_tick stays 0.
  - After en rises, pixel 300 is still presented for exactly 1 further cycle (the held div_cnt = 1 resumes), then 301 follows.
- reset asserted for 1 cycle at line 200, pixel 500:
  - The next cycle shows h_cnt = 0, v_cnt = 0, valid = 1 and inactive syncs.
  - The following frame_start arrives 420000 cycles later.
- Small geometry: HD=4, HF=1, HS=2, HB=1, VD=3, VF=1, VS=1, VB=1, HSYNC_POL=1, CW=4:
  - hsync is high at pixels 5..6 only.
  - vsync is low for line 4.
  - The wrap 7 -> 0 advances the line, and the line wrap 5 -> 0 occurs.
  - frame_start repeats every 48 cycles.
